// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator.
// Holds the FSM state enum, next-PC select enum, default width and reset PC.
package fetch_pkg;

   localparam int FETCH_WIDTH = 11;
   localparam logic [FETCH_WIDTH-1:0] RESET_PC_DEF = 11'h000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_INC  = 2'd1,
      SEL_BR   = 2'd2,
      SEL_PEND = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC mux: hold, increment (wrapping), branch or pending target.
// Ports: sel, pc, br_target, pend_tgt in; next_pc out.
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter int WIDTH = FETCH_WIDTH
) (
   input  pc_sel_e          sel,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] br_target,
   input  logic [WIDTH-1:0] pend_tgt,
   output logic [WIDTH-1:0] next_pc
);

   always_comb begin
      next_pc = pc;
      unique case (sel)
         SEL_HOLD: next_pc = pc;
         SEL_INC:  next_pc = pc + WIDTH'(1);
         SEL_BR:   next_pc = br_target;
         SEL_PEND: next_pc = pend_tgt;
      endcase
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: IDLE/REQ/HOLD FSM issuing one fetch at a time.
// Ports: clk, rst(n), run, stall, br_valid/br_target, mem_req/addr/ack, w_en, chosen, w_data, err.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = FETCH_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   output logic             w_en,
   output logic             chosen,
   output logic [WIDTH-1:0] w_data,
   output logic             err
);

   state_e           state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pend_tgt;
   logic             squash;
   pc_sel_e          sel;
   logic [WIDTH-1:0] next_pc;

   // Decoded from state so reset drops the request immediately.
   assign mem_req  = (state == REQ);
   assign mem_addr = pc;

   // A branch coinciding with the ack overrides any pending squash target.
   always_comb begin
      sel = SEL_HOLD;
      unique case (state)
         REQ: begin
            if (mem_ack) begin
               if (br_valid)    sel = SEL_BR;
               else if (squash) sel = SEL_PEND;
               else             sel = SEL_INC;
            end
         end
         default: begin
            if (br_valid) sel = SEL_BR;
         end
      endcase
   end

   fetch_next_pc #(
      .WIDTH(WIDTH)
   ) u_next_pc (
      .sel      (sel),
      .pc       (pc),
      .br_target(br_target),
      .pend_tgt (pend_tgt),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         squash   <= 1'b0;
         pend_tgt <= '0;
         w_en     <= 1'b0;
         chosen   <= 1'b0;
         w_data   <= '0;
         err      <= 1'b0;
      end else begin
         w_en   <= 1'b0;
         chosen <= 1'b0;
         err    <= mem_ack && (state != REQ);
         pc     <= next_pc;
         unique case (state)
            IDLE: begin
               if (run) state <= REQ;
            end
            REQ: begin
               if (mem_ack) begin
                  if (!squash) begin
                     w_en   <= 1'b1;
                     chosen <= 1'b1;
                     w_data <= pc;
                  end
                  squash <= 1'b0;
                  if (!run)       state <= IDLE;
                  else if (stall) state <= HOLD;
                  else            state <= REQ;
               end else if (br_valid) begin
                  pend_tgt <= br_target;
                  squash   <= 1'b1;
               end
            end
            HOLD: begin
               if (!run)        state <= IDLE;
               else if (!stall) state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized and directed bench for fetch_pc_gen against a behavioural model.
// Model tracks fetch progress per cycle and predicts every output.
module tb_fetch_pc_gen;

   logic        clk;
   logic        rst;
   logic        run;
   logic        stall;
   logic        br_valid;
   logic [10:0] br_target;
   logic        mem_req;
   logic [10:0] mem_addr;
   logic        mem_ack;
   logic        w_en;
   logic        chosen;
   logic [10:0] w_data;
   logic        err;

   int vectors;
   int miscompares;

   // Behavioural model
   bit          m_fetching;
   bit          m_paused;
   int          m_pc;
   int          m_pend;
   bit          m_kill;
   bit          m_wen;
   int          m_wdata;
   bit          m_err;

   fetch_pc_gen dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .stall    (stall),
      .br_valid (br_valid),
      .br_target(br_target),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .w_en     (w_en),
      .chosen   (chosen),
      .w_data   (w_data),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fetching = 0;
      m_paused   = 0;
      m_pc       = 0;
      m_pend     = 0;
      m_kill     = 0;
      m_wen      = 0;
      m_wdata    = 0;
      m_err      = 0;
   endtask

   task automatic model_step(input bit r, input bit s, input bit bv,
                             input int bt, input bit ak);
      m_err = ak && !m_fetching;
      m_wen = 0;
      if (m_fetching) begin
         if (ak) begin
            if (!m_kill) begin
               m_wen   = 1;
               m_wdata = m_pc;
            end
            if (bv)          m_pc = bt;
            else if (m_kill) m_pc = m_pend;
            else             m_pc = (m_pc + 1) % 2048;
            m_kill     = 0;
            m_fetching = r && !s;
            m_paused   = r && s;
         end else if (bv) begin
            m_pend = bt;
            m_kill = 1;
         end
      end else begin
         if (bv) m_pc = bt;
         if (!m_paused) begin
            m_fetching = r;
         end else if (!r) begin
            m_paused = 0;
         end else if (!s) begin
            m_paused   = 0;
            m_fetching = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("mem_req", mem_req, m_fetching);
      chk("mem_addr", mem_addr, m_pc);
      chk("w_en", w_en, m_wen);
      chk("chosen", chosen, m_wen);
      chk("w_data", w_data, m_wdata);
      chk("err", err, m_err);
   endtask

   // One clock: apply inputs, check at negedge, step model at posedge.
   task automatic cyc(input bit r, input bit s, input bit bv,
                      input logic [10:0] bt, input bit ak);
      run       = r;
      stall     = s;
      br_valid  = bv;
      br_target = bt;
      mem_ack   = ak;
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step(r, s, bv, int'(bt), ak);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop at once.
   task automatic async_reset();
      run      = 0;
      stall    = 0;
      br_valid = 0;
      mem_ack  = 0;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_req", mem_req, 1'b0);
      chk("rst_wen", w_en, 1'b0);
      chk("rst_addr", mem_addr, 11'h000);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      run         = 0;
      stall       = 0;
      br_valid    = 0;
      br_target   = '0;
      mem_ack     = 0;
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Sequential fetch 000..002
      cyc(1, 0, 0, 11'h000, 0);
      cyc(1, 0, 0, 11'h000, 1);
      chk("seq_wd0", w_data, 11'h000);
      chk("seq_we0", w_en, 1'b1);
      cyc(1, 0, 0, 11'h000, 1);
      chk("seq_wd1", w_data, 11'h001);
      cyc(1, 0, 0, 11'h000, 1);
      chk("seq_wd2", w_data, 11'h002);
      chk("seq_addr3", mem_addr, 11'h003);

      // Wrap from 7FF
      cyc(0, 0, 0, 11'h000, 1);
      cyc(0, 0, 1, 11'h7FF, 0);
      cyc(1, 0, 0, 11'h000, 0);
      cyc(0, 0, 0, 11'h000, 1);
      chk("wrap_wd", w_data, 11'h7FF);
      chk("wrap_addr", mem_addr, 11'h000);

      // Squashed fetch of 010, redirect to 200
      cyc(1, 0, 1, 11'h010, 0);
      cyc(1, 0, 1, 11'h200, 0);
      cyc(1, 0, 0, 11'h000, 0);
      cyc(1, 0, 0, 11'h000, 0);
      cyc(1, 0, 0, 11'h000, 1);
      chk("sq_wen", w_en, 1'b0);
      chk("sq_addr", mem_addr, 11'h200);

      // Branch on ack cycle
      cyc(1, 0, 1, 11'h020, 1);
      cyc(1, 0, 1, 11'h300, 1);
      chk("brack_wd", w_data, 11'h020);
      chk("brack_we", w_en, 1'b1);
      chk("brack_addr", mem_addr, 11'h300);

      // Stall into HOLD on ack of 005
      cyc(0, 0, 1, 11'h005, 1);
      cyc(1, 0, 0, 11'h000, 0);
      cyc(1, 1, 0, 11'h000, 1);
      chk("hold_req", mem_req, 1'b0);
      chk("hold_wd", w_data, 11'h005);
      cyc(1, 1, 0, 11'h000, 0);
      cyc(1, 0, 0, 11'h000, 0);
      chk("resume_req", mem_req, 1'b1);
      chk("resume_addr", mem_addr, 11'h006);

      // Spurious ack in IDLE
      cyc(0, 0, 0, 11'h000, 1);
      cyc(0, 0, 0, 11'h000, 1);
      chk("err_hi", err, 1'b1);
      chk("err_pc", mem_addr, 11'h007);
      cyc(0, 0, 0, 11'h000, 0);
      chk("err_lo", err, 1'b0);

      // Reset while a fetch is outstanding
      cyc(1, 0, 0, 11'h000, 0);
      async_reset();
      cyc(0, 0, 0, 11'h000, 1);
      cyc(0, 0, 0, 11'h000, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit          r, s, bv, ak;
         logic [10:0] bt;
         r  = ($urandom % 8) != 0;
         s  = ($urandom % 4) == 0;
         bv = ($urandom % 6) == 0;
         bt = 11'($urandom);
         if (m_fetching) ak = ($urandom % 3) == 0;
         else            ak = ($urandom % 20) == 0;
         if (($urandom % 250) == 0) async_reset();
         else cyc(r, s, bv, bt, ak);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter WIDTH, default 11, SHALL set the address/PC width.
REQ-002 Parameter RESET_PC, default 11'h000, SHALL set the PC value loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 run  input  1  SHALL enable fetching when 1.
REQ-006 stall  input  1  SHALL request a pause after the current fetch.
REQ-007 br_valid  input  1  SHALL indicate a redirect is requested this cycle.
REQ-008 br_target  input  WIDTH  SHALL carry the redirect address.
REQ-009 mem_req  output  1  SHALL request a memory fetch.
REQ-010 mem_addr  output  WIDTH  SHALL carry the fetch address.
REQ-011 mem_ack  input  1  SHALL mark completion of the outstanding fetch.
REQ-012 w_en  output  1  SHALL be the write strobe to the downstream 11-bit address register.
REQ-013 chosen  output  1  SHALL be the select to the downstream register, equal to w_en.
REQ-014 w_data  output  WIDTH  SHALL carry the completed fetch address.
REQ-015 err  output  1  SHALL flag a protocol violation.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ and HOLD, and mem_req SHALL be 1 exactly when the state is REQ.
REQ-017 In IDLE with run=1 the FSM SHALL go to REQ next cycle; with run=0 it SHALL stay in IDLE.
REQ-018 mem_addr SHALL equal pc and SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-019 REQ SHALL hold until mem_ack=1, with no timeout.
REQ-020 On an ack cycle with no squash pending, w_en/chosen SHALL be 1 and w_data SHALL equal that mem_addr on the next cycle (latency 1, single-cycle pulse).
REQ-021 On an ack without a branch, pc SHALL become pc+1 modulo 2^WIDTH, so 11'h7FF wraps to 11'h000.
REQ-022 After an ack, the next state SHALL be IDLE if run=0, else HOLD if stall=1, else REQ; run SHALL take priority over stall.
REQ-023 HOLD SHALL move to REQ when stall=0 and run=1, and to IDLE when run=0.
REQ-024 br_valid in IDLE or HOLD SHALL load pc with br_target next cycle.
REQ-025 br_valid in REQ together with mem_ack SHALL still deliver the acked address, and pc SHALL become br_target instead of pc+1.
REQ-026 br_valid in REQ without mem_ack SHALL store br_target in pend_tgt and set squash.
REQ-027 A later br_valid before the ack SHALL overwrite pend_tgt (the last one wins).
REQ-028 On an ack with squash=1, w_en SHALL stay 0, pc SHALL become pend_tgt (or br_target if br_valid is high the same cycle), and squash SHALL clear.
REQ-029 err SHALL pulse 1 for one cycle, registered, when mem_ack=1 while mem_req=0.
REQ-030 err SHALL NOT alter the state or the pc.

Reset
REQ-031 On rst=0 the block SHALL immediately set: state=IDLE, pc=RESET_PC, squash=0, pend_tgt=0, mem_req=0, w_en=0, chosen=0, w_data=0, err=0.
REQ-032 Reset during REQ SHALL abandon the outstanding fetch, and no w_en SHALL follow.
REQ-033 The first mem_req after reset release SHALL come no earlier than 1 cycle after run=1 is sampled.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the state enum (IDLE/REQ/HOLD), FETCH_WIDTH=11 and RESET_PC_DEF.
REQ-035 Exactly one sub-module, fetch_next_pc, SHALL be used: combinational next-PC selection (hold/+1/br_target/pend_tgt).
REQ-036 All outputs except mem_req and mem_addr SHALL be driven from flops.

Verification
REQ-037 Reset release, run=1, ack 1 cycle after each req -> mem_addr 000,001,002 and w_data 000,001,002, each w_en one cycle wide.
REQ-038 pc=7FF, ack -> w_data=7FF and next mem_addr=000.
REQ-039 mem_addr=010 outstanding, br_valid with br_target=200 and no ack, ack 3 cycles later -> no w_en, next mem_addr=200.
REQ-040 br_target=300 with br_valid in the same cycle as the ack of 020 -> w_data=020 with w_en=1, next mem_addr=300.
REQ-041 stall=1 on the ack of 005 -> HOLD and mem_req=0; stall=0 -> req for 006.
REQ-042 mem_ack=1 in IDLE -> err=1 for one cycle, pc unchanged; rst=0 during REQ -> mem_req=0 at once and w_en stays 0.
